// File: rtl/gray_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : gray_pkg                                             |
// | Purpose   : Shared state encoding, direction constants and a     |
// |             reference binary-to-Gray helper for the Gray         |
// |             sequence controller and its benches.                 |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int GRAY_MAX_W = 32;

  // Reference conversion, usable by benches at any width up to 32 bits.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_gray_code_converter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : binary_to_gray_code_converter                        |
// | Purpose   : Purely combinational binary to reflected-Gray        |
// |             conversion (gray = bin ^ (bin >> 1)).                |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module binary_to_gray_code_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray_code
);

  assign gray_code = binary ^ (binary >> 1);

endmodule
`default_nettype wire

// File: rtl/gray_sequence_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : gray_sequence_controller                             |
// | Purpose   : Walks a binary count from start_val to end_val (up   |
// |             or down, modulo 2^WIDTH) and streams the Gray code   |
// |             of each count on a valid/ready output.               |
// | Options   : define GRAY_CHECK_EN to add a sticky Gray-adjacency  |
// |             checker on accepted words (err output); otherwise    |
// |             err is tied low.                                     |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module gray_sequence_controller
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q,   end_d;
  logic             dir_q,   dir_d;

  logic [WIDTH-1:0] w_gray;
  logic             w_accept;
  logic             w_at_end;

  // Gray word comes straight off the count register: no added latency.
  binary_to_gray_code_converter #(
    .WIDTH (WIDTH)
  ) u_b2g (
    .binary    (bin_q),
    .gray_code (w_gray)
  );

  assign out_valid = (state_q == ST_RUN);
  assign w_accept  = out_valid & out_ready;
  assign w_at_end  = (bin_q == end_q);

  assign gray_out  = w_gray;
  assign bin_out   = bin_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // State, count and latched run parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      start_q <= start_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and count update; abort overrides everything and freezes the count.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    start_d = start_q;
    end_d   = end_q;
    dir_d   = dir_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            bin_d   = start_val;
            start_d = start_val;
            end_d   = end_val;
            dir_d   = dir;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (!w_at_end) begin
              bin_d = (dir_q == DIR_UP) ? (bin_q + c_one) : (bin_q - c_one);
            end else if (CONTINUOUS) begin
              bin_d = start_q;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             err_q;
  logic [WIDTH-1:0] w_diff;
  logic             w_step_ok;

  assign w_diff    = prev_q ^ w_gray;
  assign w_step_ok = (w_diff != '0) && ((w_diff & (w_diff - c_one)) == '0);

  // Remember the last accepted word; the first word of a run, and the first
  // word after a continuous-mode reload, have no predecessor to compare with.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (!abort) begin
      if ((state_q == ST_IDLE) && start) begin
        have_prev_q <= 1'b0;
      end else if (w_accept) begin
        prev_q      <= w_gray;
        have_prev_q <= !(CONTINUOUS && w_at_end);
        if (have_prev_q && !w_step_ok) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_sequence_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : tb_gray_sequence_controller                          |
// | Purpose   : Self-checking bench: directed and random runs scored |
// |             against a word-list model of the expected sequence.  |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module tb_gray_sequence_controller;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst, start, abort, dir, out_ready;
  logic [W-1:0] start_val, end_val, gray_out, bin_out;
  logic         out_valid, busy, done, err;

  int total = 0;
  int bad   = 0;
  int gray_tab[N];
  int exp_q[$];

  always #5 clk = ~clk;

  gray_sequence_controller #(
    .WIDTH      (W),
    .CONTINUOUS (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .start_val (start_val),
    .end_val   (end_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray table built by reflection: second half is the mirrored first half with the new MSB set.
  function automatic void build_gray_tab();
    gray_tab[0] = 0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < (1 << k); i++)
        gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | (1 << k);
  endfunction

  // Expected binary word list for one run.
  task automatic build_exp(input int sv, input int ev, input bit up);
    int v;
    v = sv;
    exp_q.delete();
    forever begin
      exp_q.push_back(v);
      if (v == ev) break;
      v = up ? (v + 1) % N : (v + N - 1) % N;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_busy"},  int'(busy), 0);
    check_eq({tag, "_done"},  int'(done), 0);
  endtask

  // One run: abort_after >= 0 aborts when that many words were accepted;
  // hold_word >= 0 forces three cycles of backpressure on that word.
  task automatic run_seq(input int sv, input int ev, input bit up, input int ready_pct,
                         input int abort_after, input bit stray, input int hold_word);
    int accepted = 0;
    int cyc      = 0;
    int lows     = 0;
    int held;
    build_exp(sv, ev, up);
    start = 1'b1; dir = up; start_val = W'(sv); end_val = W'(ev);
    tick();
    start = 1'b0; start_val = W'($urandom); end_val = W'($urandom);
    dir = ($urandom_range(0, 1) == 1);
    while (exp_q.size() > 0) begin
      check_eq("run_valid", int'(out_valid), 1);
      check_eq("run_busy",  int'(busy), 1);
      check_eq("run_done",  int'(done), 0);
      check_eq("run_bin",   int'(bin_out), exp_q[0]);
      check_eq("run_gray",  int'(gray_out), gray_tab[exp_q[0]]);
      if (accepted == abort_after) begin
        held      = exp_q[0];
        abort     = 1'b1;
        out_ready = ($urandom_range(0, 1) == 1);
        tick();
        abort = 1'b0; out_ready = 1'b0;
        check_idle("abort");
        check_eq("abort_bin_hold", int'(bin_out), held);
        tick();
        check_idle("abort_after");
        exp_q.delete();
        return;
      end
      if (accepted == hold_word && lows < 3) begin
        out_ready = 1'b0;
        lows++;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      start = stray && ($urandom_range(0, 1) == 1);
      tick();
      start = 1'b0;
      if (out_ready) begin
        void'(exp_q.pop_front());
        accepted++;
      end
      cyc++;
      if (cyc > 600) begin
        check_eq("run_timeout_words_left", exp_q.size(), 0);
        exp_q.delete();
      end
    end
    out_ready = 1'b0;
    check_eq("end_done",  int'(done), 1);
    check_eq("end_valid", int'(out_valid), 0);
    check_eq("end_busy",  int'(busy), 1);
    tick();
    check_idle("post_done");
    check_eq("post_err", int'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv, ev, ab;
    bit up;
    build_gray_tab();
    rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
    start_val = '0; end_val = '0; out_ready = 1'b0;
    tick(); tick();
    check_idle("reset");
    check_eq("reset_bin",  int'(bin_out), 0);
    check_eq("reset_gray", int'(gray_out), 0);
    check_eq("reset_err",  int'(err), 0);
    rst = 1'b0;
    tick();
    check_idle("idle");

    // out_ready while nothing is valid changes nothing
    out_ready = 1'b1;
    tick(); tick();
    check_idle("idle_ready");
    check_eq("idle_ready_bin", int'(bin_out), 0);
    out_ready = 1'b0;

    run_seq(0, 5, 1'b1, 100, -1, 1'b0, -1);   // up run
    run_seq(1, 14, 1'b0, 100, -1, 1'b0, -1);  // down with wrap
    run_seq(3, 12, 1'b1, 100, -1, 1'b0, 2);   // backpressure on word 2
    run_seq(2, 10, 1'b1, 100, 3, 1'b0, -1);   // abort at word 3
    run_seq(7, 4, 1'b0, 60, -1, 1'b0, -1);    // new start after abort
    run_seq(9, 9, 1'b1, 100, -1, 1'b0, -1);   // single word
    run_seq(14, 1, 1'b1, 100, -1, 1'b0, -1);  // up wrap
    run_seq(0, 8, 1'b1, 70, -1, 1'b1, -1);    // stray starts while running

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; start_val = 4'd3; end_val = 4'd6; dir = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort");
    tick();
    check_idle("start_abort2");

    // reset in the middle of a run
    start = 1'b1; start_val = 4'd5; end_val = 4'd12; dir = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check_idle("midrst");
    check_eq("midrst_bin",  int'(bin_out), 0);
    check_eq("midrst_gray", int'(gray_out), 0);
    tick();
    check_idle("midrst2");

    for (int n = 0; n < 25; n++) begin
      sv = $urandom_range(0, N - 1);
      ev = $urandom_range(0, N - 1);
      up = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_seq(sv, ev, up, $urandom_range(30, 100), ab, ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1);
    end

`ifdef GRAY_CHECK_EN
    start = 1'b1; dir = 1'b1; start_val = 4'd0; end_val = 4'd10;
    tick();
    start = 1'b0; out_ready = 1'b1;
    tick();
    force dut.w_gray = 4'b0110;
    tick();
    release dut.w_gray;
    out_ready = 1'b0;
    check_eq("chk_err_set", int'(err), 1);
    tick(); tick();
    check_eq("chk_err_sticky", int'(err), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("chk_err_after_abort", int'(err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("chk_err_cleared", int'(err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
